// File: rtl/xbar_l2_arb_lat_if.sv
// Master/bank signal bundle for the L2 crossbar. The slave modport is the crossbar's view;
// the master modport is the environment (masters and banks) driving it.
interface xbar_l2_arb_lat_if #(
    parameter int N_MASTER       = 5,
    parameter int N_SLAVE        = 4,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 64
);
    localparam int ADDR_IN_WIDTH = ADDR_MEM_WIDTH + $clog2(N_SLAVE);
    localparam int BE_WIDTH      = DATA_WIDTH / 8;

    logic [N_MASTER-1:0]                    data_req_i;
    logic [N_MASTER-1:0][ADDR_IN_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0]                    data_wen_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0]    data_wdata_i;
    logic [N_MASTER-1:0][BE_WIDTH-1:0]      data_be_i;
    logic [N_MASTER-1:0]                    data_gnt_o;
    logic [N_MASTER-1:0]                    data_r_valid_o;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0]    data_r_rdata_o;

    logic [N_SLAVE-1:0]                     data_req_o;
    logic [N_SLAVE-1:0][ADDR_MEM_WIDTH-1:0] data_add_o;
    logic [N_SLAVE-1:0]                     data_wen_o;
    logic [N_SLAVE-1:0][DATA_WIDTH-1:0]     data_wdata_o;
    logic [N_SLAVE-1:0][BE_WIDTH-1:0]       data_be_o;
    logic [N_SLAVE-1:0]                     data_gnt_i;
    logic [N_SLAVE-1:0][DATA_WIDTH-1:0]     data_r_rdata_i;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o,
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
        input  data_gnt_i, data_r_rdata_i
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
        output data_gnt_i, data_r_rdata_i
    );
endinterface

// File: rtl/xbar_l2_arb_lat.sv
// Word-interleaved L2 crossbar: per-bank two-level arbiter (CH1 over CH0 with a CH0
// starvation guard), bank backpressure and fixed-latency internal response routing.
module xbar_l2_arb_lat_bank #(
    parameter int N_CH0          = 4,
    parameter int N_CH1          = 1,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_LATENCY    = 1,
    parameter int STARVE_LIMIT   = 4,
    localparam int N_MASTER      = N_CH0 + N_CH1,
    localparam int BE_WIDTH      = DATA_WIDTH / 8,
    localparam int MIDX_W        = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_MASTER-1:0]                     req,
    input  logic [N_MASTER-1:0][ADDR_MEM_WIDTH-1:0] row,
    input  logic [N_MASTER-1:0]                     wen,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]     wdata,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]       be,
    input  logic                                    bank_gnt,
    output logic                                    bank_req,
    output logic [ADDR_MEM_WIDTH-1:0]               bank_add,
    output logic                                    bank_wen,
    output logic [DATA_WIDTH-1:0]                   bank_wdata,
    output logic [BE_WIDTH-1:0]                     bank_be,
    output logic [N_MASTER-1:0]                     gnt,
    output logic                                    rsp_vld,
    output logic [MIDX_W-1:0]                       rsp_idx
);
    localparam int N1   = (N_CH1 > 0) ? N_CH1 : 1;
    localparam int P0_W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
    localparam int P1_W = (N1 > 1) ? $clog2(N1) : 1;
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [P0_W-1:0] rr0, win0, hi0, lo0;
    logic [P1_W-1:0] rr1, win1, hi1, lo1;
    logic [SC_W-1:0] starve;
    logic            any0, any1, hit0, hit1, use0, fire;
    logic [MIDX_W-1:0] win;
    logic [MEM_LATENCY-1:0]             vld_pipe;
    logic [MEM_LATENCY-1:0][MIDX_W-1:0] idx_pipe;

    // Round-robin: first requester at or above the pointer, else the lowest requester (wrap).
    always_comb begin
        any0 = 1'b0; hit0 = 1'b0; hi0 = '0; lo0 = '0;
        any1 = 1'b0; hit1 = 1'b0; hi1 = '0; lo1 = '0;
        for (int m = 0; m < N_CH0; m++) begin
            if (req[m]) begin
                if (!any0) lo0 = P0_W'(m);
                any0 = 1'b1;
                if (!hit0 && P0_W'(m) >= rr0) begin
                    hit0 = 1'b1;
                    hi0  = P0_W'(m);
                end
            end
        end
        for (int m = 0; m < N_CH1; m++) begin
            if (req[N_CH0+m]) begin
                if (!any1) lo1 = P1_W'(m);
                any1 = 1'b1;
                if (!hit1 && P1_W'(m) >= rr1) begin
                    hit1 = 1'b1;
                    hi1  = P1_W'(m);
                end
            end
        end
        win0 = hit0 ? hi0 : lo0;
        win1 = hit1 ? hi1 : lo1;
    end

    always_comb begin
        use0       = any0 && (!any1 || starve == SC_W'(STARVE_LIMIT));
        win        = use0 ? MIDX_W'(win0) : MIDX_W'(N_CH0) + MIDX_W'(win1);
        bank_req   = any0 | any1;
        fire       = bank_req & bank_gnt;
        bank_add   = '0;
        bank_wen   = 1'b0;
        bank_wdata = '0;
        bank_be    = '0;
        gnt        = '0;
        if (bank_req) begin
            bank_add   = row[win];
            bank_wen   = wen[win];
            bank_wdata = wdata[win];
            bank_be    = be[win];
            gnt[win]   = bank_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr0    <= '0;
            rr1    <= '0;
            starve <= '0;
        end else if (fire && use0) begin
            rr0    <= (win0 == P0_W'(N_CH0 - 1)) ? '0 : win0 + 1'b1;
            starve <= '0;
        end else begin
            if (fire) rr1 <= (win1 == P1_W'(N1 - 1)) ? '0 : win1 + 1'b1;
            // A denied CH0 requester (lost to CH1 or stalled by the bank) ages the guard.
            if (any0 && starve != SC_W'(STARVE_LIMIT)) starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[0] <= fire;
            idx_pipe[0] <= win;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    assign rsp_vld = vld_pipe[MEM_LATENCY-1];
    assign rsp_idx = idx_pipe[MEM_LATENCY-1];
endmodule

module xbar_l2_arb_lat #(
    parameter int N_CH0          = 4,
    parameter int N_CH1          = 1,
    parameter int N_SLAVE        = 4,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_LATENCY    = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input logic              clk,
    input logic              rst_n,
    xbar_l2_arb_lat_if.slave bus
);
    localparam int N_MASTER      = N_CH0 + N_CH1;
    localparam int BE_WIDTH      = DATA_WIDTH / 8;
    localparam int BANK_BITS     = $clog2(N_SLAVE);
    localparam int BANK_W        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ADDR_IN_WIDTH = ADDR_MEM_WIDTH + BANK_BITS;
    localparam int MIDX_W        = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic [N_MASTER-1:0][BANK_W-1:0]          bank_sel;
    logic [N_MASTER-1:0][ADDR_MEM_WIDTH-1:0]  row;
    logic [N_SLAVE-1:0][N_MASTER-1:0]         bank_hit, bank_gnt;
    logic [N_SLAVE-1:0]                       rsp_vld;
    logic [N_SLAVE-1:0][MIDX_W-1:0]           rsp_idx;
    logic [N_SLAVE-1:0]                       s_req, s_wen;
    logic [N_SLAVE-1:0][ADDR_MEM_WIDTH-1:0]   s_add;
    logic [N_SLAVE-1:0][DATA_WIDTH-1:0]       s_wdata;
    logic [N_SLAVE-1:0][BE_WIDTH-1:0]         s_be;
    logic [N_MASTER-1:0]                      gnt, r_valid;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0]      r_rdata;

    for (genvar m = 0; m < N_MASTER; m++) begin : g_route
        if (N_SLAVE == 1) begin : g_one
            assign bank_sel[m] = '0;
            assign row[m]      = bus.data_add_i[m];
        end else begin : g_many
            assign bank_sel[m] = bus.data_add_i[m][BANK_BITS-1:0];
            assign row[m]      = bus.data_add_i[m][ADDR_IN_WIDTH-1:BANK_BITS];
        end
    end

    always_comb begin
        for (int s = 0; s < N_SLAVE; s++)
            for (int m = 0; m < N_MASTER; m++)
                bank_hit[s][m] = bus.data_req_i[m] && (bank_sel[m] == BANK_W'(s));
    end

    for (genvar s = 0; s < N_SLAVE; s++) begin : g_bank
        xbar_l2_arb_lat_bank #(
            .N_CH0(N_CH0), .N_CH1(N_CH1), .ADDR_MEM_WIDTH(ADDR_MEM_WIDTH),
            .DATA_WIDTH(DATA_WIDTH), .MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (bank_hit[s]),
            .row        (row),
            .wen        (bus.data_wen_i),
            .wdata      (bus.data_wdata_i),
            .be         (bus.data_be_i),
            .bank_gnt   (bus.data_gnt_i[s]),
            .bank_req   (s_req[s]),
            .bank_add   (s_add[s]),
            .bank_wen   (s_wen[s]),
            .bank_wdata (s_wdata[s]),
            .bank_be    (s_be[s]),
            .gnt        (bank_gnt[s]),
            .rsp_vld    (rsp_vld[s]),
            .rsp_idx    (rsp_idx[s])
        );
    end

    // A master holds at most one grant per cycle and latency is uniform, so at most one
    // bank targets any master in a given cycle.
    always_comb begin
        gnt     = '0;
        r_valid = '0;
        r_rdata = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            gnt |= bank_gnt[s];
            for (int m = 0; m < N_MASTER; m++) begin
                if (rsp_vld[s] && rsp_idx[s] == MIDX_W'(m)) begin
                    r_valid[m] = 1'b1;
                    r_rdata[m] = bus.data_r_rdata_i[s];
                end
            end
        end
    end

    assign bus.data_gnt_o     = gnt;
    assign bus.data_r_valid_o = r_valid;
    assign bus.data_r_rdata_o = r_rdata;
    assign bus.data_req_o     = s_req;
    assign bus.data_add_o     = s_add;
    assign bus.data_wen_o     = s_wen;
    assign bus.data_wdata_o   = s_wdata;
    assign bus.data_be_o      = s_be;
endmodule

// File: tb/tb_xbar_l2_arb_lat.sv
// Bench for xbar_l2_arb_lat: a 4-bank/latency-2 instance and a single-bank/latency-3
// instance, directed scenarios plus random traffic against a per-cycle reference model.
module tb_xbar_l2_arb_lat;
    localparam int NM = 5, N0 = 4, N1 = 1, LIM = 4;
    localparam int NSL[2] = '{4, 1};
    localparam int LAT[2] = '{2, 3};

    logic clk, rst_a, rst_b;
    int n_tests = 0, n_fail = 0, cyc = 0;

    logic [1:0][NM-1:0]        req, wen;
    logic [1:0][NM-1:0][13:0]  add;
    logic [1:0][NM-1:0][63:0]  wdata;
    logic [1:0][NM-1:0][7:0]   be;
    logic [1:0][3:0]           bgnt;
    logic [1:0][3:0][63:0]     brdata;

    logic [1:0][3:0]           obs_req, obs_wen;
    logic [1:0][3:0][11:0]     obs_add;
    logic [1:0][3:0][63:0]     obs_wd;
    logic [1:0][3:0][7:0]      obs_be;
    logic [1:0][NM-1:0]        obs_gnt, obs_rv;
    logic [1:0][NM-1:0][63:0]  obs_rd;

    xbar_l2_arb_lat_if #(.N_MASTER(NM), .N_SLAVE(4), .ADDR_MEM_WIDTH(12), .DATA_WIDTH(64)) bus_a ();
    xbar_l2_arb_lat_if #(.N_MASTER(NM), .N_SLAVE(1), .ADDR_MEM_WIDTH(12), .DATA_WIDTH(64)) bus_b ();

    xbar_l2_arb_lat #(.N_CH0(N0), .N_CH1(N1), .N_SLAVE(4), .ADDR_MEM_WIDTH(12), .DATA_WIDTH(64),
                      .MEM_LATENCY(2), .STARVE_LIMIT(LIM))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
    xbar_l2_arb_lat #(.N_CH0(N0), .N_CH1(N1), .N_SLAVE(1), .ADDR_MEM_WIDTH(12), .DATA_WIDTH(64),
                      .MEM_LATENCY(3), .STARVE_LIMIT(LIM))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));

    assign bus_a.data_req_i     = req[0];
    assign bus_a.data_add_i     = add[0];
    assign bus_a.data_wen_i     = wen[0];
    assign bus_a.data_wdata_i   = wdata[0];
    assign bus_a.data_be_i      = be[0];
    assign bus_a.data_gnt_i     = bgnt[0];
    assign bus_a.data_r_rdata_i = brdata[0];
    assign bus_b.data_req_i     = req[1];
    for (genvar m = 0; m < NM; m++) begin : g_badd
        assign bus_b.data_add_i[m] = add[1][m][11:0];
    end
    assign bus_b.data_wen_i     = wen[1];
    assign bus_b.data_wdata_i   = wdata[1];
    assign bus_b.data_be_i      = be[1];
    assign bus_b.data_gnt_i     = bgnt[1][0];
    assign bus_b.data_r_rdata_i = brdata[1][0];

    assign obs_req[0] = bus_a.data_req_o;   assign obs_req[1] = {3'b0, bus_b.data_req_o};
    assign obs_wen[0] = bus_a.data_wen_o;   assign obs_wen[1] = {3'b0, bus_b.data_wen_o};
    assign obs_add[0] = bus_a.data_add_o;   assign obs_add[1] = {36'b0, bus_b.data_add_o};
    assign obs_wd[0]  = bus_a.data_wdata_o; assign obs_wd[1]  = {192'b0, bus_b.data_wdata_o};
    assign obs_be[0]  = bus_a.data_be_o;    assign obs_be[1]  = {24'b0, bus_b.data_be_o};
    assign obs_gnt[0] = bus_a.data_gnt_o;   assign obs_gnt[1] = bus_b.data_gnt_o;
    assign obs_rv[0]  = bus_a.data_r_valid_o; assign obs_rv[1] = bus_b.data_r_valid_o;
    assign obs_rd[0]  = bus_a.data_r_rdata_o; assign obs_rd[1] = bus_b.data_r_rdata_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: arbitration state per bank and a list of outstanding responses.
    typedef struct { int d; int due; int m; int s; } rsp_t;
    rsp_t rq[$];
    int rr0[2][4], rr1[2][4], stv[2][4];

    function automatic int bank_of(int d, int m);
        return (NSL[d] == 1) ? 0 : int'(add[d][m][1:0]);
    endfunction

    function automatic logic [11:0] row_of(int d, int m);
        return (NSL[d] == 1) ? add[d][m][11:0] : add[d][m][13:2];
    endfunction

    task automatic model_step(input int d);
        logic [3:0] e_req, e_wen;
        logic [3:0][11:0] e_add;
        logic [3:0][63:0] e_wd;
        logic [3:0][7:0] e_be;
        logic [NM-1:0] e_gnt, e_rv;
        logic [NM-1:0][63:0] e_rd;
        int best0, best1, dist0, dist1, dd, w;
        int n_rr0[4], n_rr1[4], n_stv[4];
        bit in_rst;
        string p;
        p = (d == 0) ? "a" : "b";
        in_rst = (d == 0) ? !rst_a : !rst_b;
        if (in_rst) begin
            for (int s = 0; s < 4; s++) begin rr0[d][s] = 0; rr1[d][s] = 0; stv[d][s] = 0; end
            for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].d == d) rq.delete(i);
        end
        e_req = '0; e_wen = '0; e_add = '0; e_wd = '0; e_be = '0;
        e_gnt = '0; e_rv = '0; e_rd = '0;
        for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].d == d && rq[i].due == cyc) begin
                e_rv[rq[i].m] = 1'b1;
                e_rd[rq[i].m] = brdata[d][rq[i].s];
                rq.delete(i);
            end
        end
        for (int s = 0; s < 4; s++) begin
            n_rr0[s] = rr0[d][s]; n_rr1[s] = rr1[d][s]; n_stv[s] = stv[d][s];
        end
        for (int s = 0; s < NSL[d]; s++) begin
            best0 = -1; best1 = -1; dist0 = 99; dist1 = 99;
            for (int m = 0; m < NM; m++) begin
                if (req[d][m] && bank_of(d, m) == s) begin
                    if (m < N0) begin
                        dd = (m - rr0[d][s] + N0) % N0;
                        if (dd < dist0) begin dist0 = dd; best0 = m; end
                    end else begin
                        dd = (m - N0 - rr1[d][s] + N1) % N1;
                        if (dd < dist1) begin dist1 = dd; best1 = m; end
                    end
                end
            end
            if (best0 >= 0 || best1 >= 0) begin
                w = (best0 >= 0 && (stv[d][s] == LIM || best1 < 0)) ? best0 : best1;
                e_req[s] = 1'b1;
                e_add[s] = row_of(d, w);
                e_wen[s] = wen[d][w];
                e_wd[s]  = wdata[d][w];
                e_be[s]  = be[d][w];
                if (bgnt[d][s]) begin
                    e_gnt[w] = 1'b1;
                    if (!in_rst) rq.push_back('{d, cyc + LAT[d], w, s});
                    if (w < N0) n_rr0[s] = (w + 1) % N0;
                    else        n_rr1[s] = (w - N0 + 1) % N1;
                end
                if (bgnt[d][s] && w < N0) n_stv[s] = 0;
                else if (best0 >= 0)      n_stv[s] = (stv[d][s] < LIM) ? stv[d][s] + 1 : LIM;
            end
        end
        chk({p, ".req"}, obs_req[d], e_req);
        chk({p, ".add"}, obs_add[d], e_add);
        chk({p, ".wen"}, obs_wen[d], e_wen);
        chk({p, ".wdata"}, obs_wd[d], e_wd);
        chk({p, ".be"}, obs_be[d], e_be);
        chk({p, ".gnt"}, obs_gnt[d], e_gnt);
        chk({p, ".rvalid"}, obs_rv[d], e_rv);
        chk({p, ".rdata"}, obs_rd[d], e_rd);
        if (!in_rst)
            for (int s = 0; s < 4; s++) begin
                rr0[d][s] = n_rr0[s]; rr1[d][s] = n_rr1[s]; stv[d][s] = n_stv[s];
            end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) step();
    endtask

    initial begin
        req = '0; add = '0; wen = '0; wdata = '0; be = '0; bgnt = '1; brdata = '0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) step();
        chk("reset.rvalid", obs_rv, '0);
        chk("reset.rdata", obs_rd, '0);
        rst_a = 1'b1; rst_b = 1'b1;

        // CH1 wins four times, then the starved CH0 master gets the bank.
        add[0][0] = 14'h0; add[0][4] = {12'h3, 2'd0}; wen[0] = '1;
        for (int c = 0; c < 10; c++) begin
            req[0] = 5'b10001;
            #2 chk("starve.gnt", obs_gnt[0], (c % 5 == 4) ? 5'b00001 : 5'b10000);
            step();
        end
        idle(3);

        for (int m = 0; m < N0; m++) add[0][m] = {12'(m + 8), 2'd2};
        for (int c = 0; c < 6; c++) begin
            req[0] = 5'b01111;
            #2 chk("rr.gnt", obs_gnt[0], 5'(1 << (c % 4)));
            step();
        end
        idle(3);

        req[0] = 5'b00011; add[0][0] = 14'h5; add[0][1] = 14'h6; wen[0] = 5'b00011;
        #2 chk("par.gnt", obs_gnt[0], 5'b00011);
        chk("par.add1", obs_add[0][1], 12'h1);
        chk("par.add2", obs_add[0][2], 12'h1);
        step(); req[0] = '0;
        #2 chk("par.t1", obs_rv[0], 5'b0);
        step(); brdata[0][1] = 64'hA1; brdata[0][2] = 64'hB2;
        #2 chk("par.rvalid", obs_rv[0], 5'b00011);
        chk("par.rd0", obs_rd[0][0], 64'hA1);
        chk("par.rd1", obs_rd[0][1], 64'hB2);
        idle(3);

        req[0] = 5'b00100; add[0][2] = {12'h33, 2'd0}; bgnt[0][0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2 chk("bp.req", obs_req[0][0], 1'b1);
            chk("bp.add", obs_add[0][0], 12'h33);
            chk("bp.gnt", obs_gnt[0][2], 1'b0);
            step();
        end
        bgnt[0][0] = 1'b1;
        #2 chk("bp.gnt4", obs_gnt[0][2], 1'b1);
        step(); req[0] = '0;
        #2 chk("bp.early", obs_rv[0], 5'b0);
        step();
        #2 chk("bp.rvalid", obs_rv[0], 5'b00100);
        idle(3);

        req[1] = 5'b00010; add[1][1] = 14'h7F; wen[1] = '1;
        #2 chk("single.add", obs_add[1][0], 12'h7F);
        chk("single.gnt", obs_gnt[1], 5'b00010);
        step(); req[1] = '0;
        step(); step(); brdata[1][0] = 64'hC0DE_0000_1234_5678;
        #2 chk("single.rvalid", obs_rv[1], 5'b00010);
        chk("single.rdata", obs_rd[1][1], 64'hC0DE_0000_1234_5678);
        idle(4);

        // Leave rr_ptr=2 and a part-aged starve counter, then reset with two reads in flight.
        brdata[1][0] = 64'h5555;
        req[1] = 5'b00010; add[1][1] = 14'h0;
        step();
        req[1] = 5'b10001; add[1][0] = 14'h1; add[1][4] = 14'h2;
        #2 chk("rst.pre", obs_gnt[1], 5'b10000);
        step();
        req[1] = '0; rst_b = 1'b0;
        #1 chk("rst.rvalid", obs_rv[1], 5'b0);
        step();
        #2 chk("rst.hold", obs_rv[1], 5'b0);
        step();
        rst_b = 1'b1; req[1] = 5'b10101; add[1][2] = 14'h3;
        for (int c = 0; c < 5; c++) begin
            #2 chk("rst.after", obs_gnt[1], (c == 4) ? 5'b00001 : 5'b10000);
            if (c < 2) chk("rst.drop", obs_rv[1], 5'b0);
            step();
        end
        idle(4);

        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < NM; m++) begin
                    req[d][m]   = ($urandom % 3) != 0;
                    add[d][m]   = 14'($urandom);
                    wen[d][m]   = 1'($urandom);
                    wdata[d][m] = {$urandom, $urandom};
                    be[d][m]    = 8'($urandom);
                end
                for (int s = 0; s < 4; s++) begin
                    bgnt[d][s]   = ($urandom % 4) != 0;
                    brdata[d][s] = {$urandom, $urandom};
                end
            end
            rst_a = !(c == 150 || c == 151);
            step();
        end
        rst_a = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
